// File: rtl/twos_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : twos_mul_seq
// Purpose  : Signed WIDTH x WIDTH multiply sequencer around an unsigned core,
//            time-sharing one external 2*WIDTH two's-complement negator.
// Revision : 1.0 - initial release
// ============================================================================
module twos_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic [2*WIDTH-1:0]   twos_i,
    input  logic [2*WIDTH-1:0]   twos_o,
    output logic                 mul_start,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic                 mul_done,
    input  logic [2*WIDTH-1:0]   mul_p,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic                 busy
);

    localparam int         c_PW     = 2 * WIDTH;
    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_NEG_A  = 3'd1;
    localparam logic [2:0] c_NEG_B  = 3'd2;
    localparam logic [2:0] c_MUL    = 3'd3;
    localparam logic [2:0] c_NEG_P  = 3'd4;
    localparam logic [2:0] c_DONE   = 3'd5;

    logic [2:0]       r_state;
    logic [WIDTH-1:0] r_b;
    logic             r_sign_p;

    function automatic logic [c_PW-1:0] f_sext(input logic [WIDTH-1:0] v);
        return {{WIDTH{v[WIDTH-1]}}, v};
    endfunction

    // Outputs are registered: each transition loads the values the next state presents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_b       <= '0;
            r_sign_p  <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            mul_start <= 1'b0;
            twos_i    <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            out_p     <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_b      <= in_b;
                        r_sign_p <= in_a[WIDTH-1] ^ in_b[WIDTH-1];
                        mul_a    <= in_a;
                        mul_b    <= in_b;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (in_a[WIDTH-1]) begin
                            twos_i  <= f_sext(in_a);
                            r_state <= c_NEG_A;
                        end else if (in_b[WIDTH-1]) begin
                            twos_i  <= f_sext(in_b);
                            r_state <= c_NEG_B;
                        end else begin
                            mul_start <= 1'b1;
                            r_state   <= c_MUL;
                        end
                    end
                end
                c_NEG_A: begin
                    mul_a <= twos_o[WIDTH-1:0];
                    if (r_b[WIDTH-1]) begin
                        twos_i  <= f_sext(r_b);
                        r_state <= c_NEG_B;
                    end else begin
                        twos_i    <= '0;
                        mul_start <= 1'b1;
                        r_state   <= c_MUL;
                    end
                end
                c_NEG_B: begin
                    mul_b     <= twos_o[WIDTH-1:0];
                    twos_i    <= '0;
                    mul_start <= 1'b1;
                    r_state   <= c_MUL;
                end
                c_MUL: begin
                    mul_start <= 1'b0;
                    // mul_start is high only in the start cycle, where mul_done is not trusted.
                    if (!mul_start && mul_done) begin
                        if (r_sign_p) begin
                            twos_i  <= mul_p;
                            r_state <= c_NEG_P;
                        end else begin
                            out_p     <= mul_p;
                            out_valid <= 1'b1;
                            r_state   <= c_DONE;
                        end
                    end
                end
                c_NEG_P: begin
                    out_p     <= twos_o;
                    twos_i    <= '0;
                    out_valid <= 1'b1;
                    r_state   <= c_DONE;
                end
                c_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= c_IDLE;
                    end
                end
                default: begin
                    r_state   <= c_IDLE;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    mul_start <= 1'b0;
                    twos_i    <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
